// File: rtl/puf_race_launcher.sv
// Arbiter-PUF race launcher: walks an LFSR challenge sequence, fires one race edge per challenge
// and collects the synchronized arbiter bits into a response word. Optional macro: MAJORITY_VOTE_EN.
module puf_race_launcher #(
    parameter int unsigned RESP_W     = 16,
    parameter int unsigned PRE_CYC    = 4,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       seed_i,
    output logic [31:0]       chal_o,
    output logic              launch_o,
    input  logic              arb_in_i,
    output logic              busy_o,
    output logic [RESP_W-1:0] resp_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_RACE   = 3'd2,
        S_SAMPLE = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int unsigned CNT_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int unsigned PH_W  = 16;
    localparam logic [PH_W-1:0]  PRE_LAST    = PH_W'(PRE_CYC - 1);
    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(RESP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Fibonacci LFSR x^32+x^22+x^2+x+1, shifting toward the MSB.
    function automatic logic [31:0] lfsr_step(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t             state_q;
    logic [31:0]        chal_q;
    logic               launch_q;
    logic               busy_q;
    logic [RESP_W-1:0]  resp_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PH_W-1:0]    ph_q;
    logic               sync1_q;
    logic               sync2_q;
`ifdef MAJORITY_VOTE_EN
    logic [1:0]         rep_q;
    logic [1:0]         votes_q;
`endif

    logic [31:0]        lfsr_d;
    logic [31:0]        seed_d;
    logic               sample_bit;
    logic [RESP_W-1:0]  resp_d;

    assign lfsr_d = lfsr_step(chal_q);
    assign seed_d = (seed_i == 32'h0) ? 32'h1 : seed_i;

`ifdef MAJORITY_VOTE_EN
    assign sample_bit = maj3(votes_q[0], votes_q[1], sync2_q);
`else
    assign sample_bit = sync2_q;
`endif

    // Response word with the current bit position replaced by the resolved sample.
    always_comb begin
        resp_d        = resp_q;
        resp_d[cnt_q] = sample_bit;
    end

    // Two-flop synchronizer for the asynchronous SR-arbiter output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= arb_in_i;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer: precharge, race, sample, advance challenge, then hold the word until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            chal_q   <= 32'h0;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            resp_q   <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
            ph_q     <= '0;
`ifdef MAJORITY_VOTE_EN
            rep_q    <= 2'd0;
            votes_q  <= 2'b00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        chal_q   <= seed_d;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        resp_q   <= '0;
                        ph_q     <= '0;
                        launch_q <= 1'b0;
`ifdef MAJORITY_VOTE_EN
                        rep_q    <= 2'd0;
                        votes_q  <= 2'b00;
`endif
                        state_q  <= S_PRE;
                    end else begin
                        state_q  <= S_IDLE;
                    end
                end
                S_PRE: begin
                    if (ph_q == PRE_LAST) begin
                        ph_q     <= '0;
                        launch_q <= 1'b1;
                        state_q  <= S_RACE;
                    end else begin
                        ph_q     <= ph_q + 16'd1;
                    end
                end
                S_RACE: begin
                    if (ph_q == SETTLE_LAST) begin
                        ph_q    <= '0;
                        state_q <= S_SAMPLE;
                    end else begin
                        ph_q    <= ph_q + 16'd1;
                    end
                end
                S_SAMPLE: begin
                    launch_q <= 1'b0;
`ifdef MAJORITY_VOTE_EN
                    // The first two samples are banked; the third resolves the vote.
                    if (rep_q == 2'd2) begin
                        resp_q  <= resp_d;
                        rep_q   <= 2'd0;
                        state_q <= S_NEXT;
                    end else begin
                        votes_q[rep_q[0]] <= sync2_q;
                        rep_q   <= rep_q + 2'd1;
                        state_q <= S_PRE;
                    end
`else
                    resp_q   <= resp_d;
                    state_q  <= S_NEXT;
`endif
                end
                S_NEXT: begin
                    chal_q <= lfsr_d;
                    if (cnt_q == CNT_LAST) begin
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        state_q <= S_PRE;
                    end
                end
                S_DONE: begin
                    if (resp_ready_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    launch_q <= 1'b0;
                    busy_q   <= 1'b0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign chal_o       = chal_q;
    assign launch_o     = launch_q;
    assign busy_o       = busy_q;
    assign resp_o       = resp_q;
    assign resp_valid_o = valid_q;

endmodule
